fp16_byte_serializer: RTL



---
 rtl/fp16_byte_serializer_if.sv | 22 ++
 rtl/fp16_byte_serializer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fp16_byte_serializer_if.sv
// Result-side bus of the FP16 tile: word handshake in, byte stream and status out.
// The valid/ready handshake is as follows. A word transfers on a rising edge where in_valid and in_ready are both high.
// in_ready never depends on in_valid, and in_data only needs to be stable while in_valid is high.
interface fp16_byte_serializer_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  uo_out;
  logic        out_strobe;
  logic        out_last;
  logic        busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, uo_out, out_strobe, out_last, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, uo_out, out_strobe, out_last, busy
  );
endinterface

// File: rtl/fp16_byte_serializer.sv
// Buffers 16-bit results in a small FIFO and streams each word as two bytes,
// low byte first, with registered byte/strobe/last outputs.
module fp16_byte_serializer #(
    parameter int          DEPTH     = 2,
    parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    fp16_byte_serializer_if.slave bus,
    output logic [1:0]            dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]  count;
    logic           full, push, pop;
    logic [15:0]    next_head;
    logic [7:0]     uo_q, uo_d;
    logic           strobe_q, strobe_d, last_q, last_d;

    assign full          = (count == CW'(DEPTH));
    assign bus.in_ready  = ena && !full;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = ena && (state_q == SEND_HI);
    assign rd_ptr_nxt    = rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr_nxt;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            uo_q     <= IDLE_BYTE;
            strobe_q <= 1'b0;
            last_q   <= 1'b0;
        end else if (ena) begin
            state_q  <= state_d;
            uo_q     <= uo_d;
            strobe_q <= strobe_d;
            last_q   <= last_d;
        end
    end

    // Outputs are loaded from the next state, so the byte for a fresh SEND_LO
    // must come from the word that will be at the head after this edge's pop.
    always_comb begin
        state_d   = state_q;
        next_head = mem[rd_ptr];
        uo_d      = IDLE_BYTE;
        strobe_d  = 1'b0;
        last_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) state_d = SEND_LO;
            end
            SEND_LO: begin
                state_d = SEND_HI;
            end
            SEND_HI: begin
                if (count > CW'(1)) begin
                    state_d   = SEND_LO;
                    next_head = mem[rd_ptr_nxt];
                end else if (push) begin
                    // Sole word leaves as the pushed one arrives: bypass the write.
                    state_d   = SEND_LO;
                    next_head = bus.in_data;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            SEND_LO: begin
                uo_d     = next_head[7:0];
                strobe_d = 1'b1;
                last_d   = 1'b0;
            end
            SEND_HI: begin
                uo_d     = mem[rd_ptr][15:8];
                strobe_d = 1'b1;
                last_d   = 1'b1;
            end
            default: begin
                uo_d     = IDLE_BYTE;
                strobe_d = 1'b0;
                last_d   = 1'b0;
            end
        endcase
    end

    assign bus.uo_out     = uo_q;
    assign bus.out_strobe = strobe_q && ena;
    assign bus.out_last   = last_q;
    assign bus.busy       = (count != '0) || (state_q != IDLE);
    assign dbg_state      = state_q;
endmodule
